// File: rtl/hazard_issue_ctrl.sv
// Issue gate between decode and the in-flight hazard FIFO: RAW stall, bubble push, drain and watchdog.
// Optional build macro HAZARD_ISSUE_PERF_EN adds stall-cycle and issue performance counters.
`timescale 1ns/1ps
module hazard_issue_ctrl #(
    parameter int DEPTH      = 9,
    parameter int LAT_SCALAR = 3,
    parameter int LAT_MEM    = 5,
    parameter int LAT_VEC    = 4,
    parameter int LAT_VFP    = 9,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        freeze_i,
    input  logic                        id_valid_i,
    input  logic [2:0][4:0]             id_src_reg_i,
    input  logic [2:0]                  id_src_vec_i,
    input  logic [2:0]                  id_src_use_i,
    input  logic [1:0]                  id_op_type_i,
    input  logic [4:0]                  id_dst_reg_i,
    input  logic                        id_vec_wr_en_i,
    input  logic                        id_reg_wr_en_i,
    input  logic                        drain_req_i,
    input  logic [DEPTH-1:0][1:0]       op_types_i,
    input  logic [DEPTH-1:0]            vector_wr_ens_i,
    input  logic [DEPTH-1:0]            register_wr_ens_i,
    input  logic [DEPTH-1:0][4:0]       write_registers_i,
`ifdef HAZARD_ISSUE_PERF_EN
    output logic [31:0]                 perf_stall_cycles_o,
    output logic [31:0]                 perf_issue_cnt_o,
`endif
    output logic                        stall_o,
    output logic                        issue_o,
    output logic                        fifo_en_o,
    output logic [1:0]                  fifo_op_type_o,
    output logic [4:0]                  fifo_wr_reg_o,
    output logic                        fifo_vec_wr_en_o,
    output logic                        fifo_reg_wr_en_o,
    output logic                        drain_done_o,
    output logic                        hazard_timeout_o
);

    // state  | meaning
    // RUN    | issuing normally
    // STALL  | RAW hazard holds decode
    // DRAIN  | fence: waiting for all pending writes to leave the FIFO
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        hazard_timeout_q;
    logic        conflict;
    logic        wr_match;
    logic        hazard;
    logic        fifo_clear;

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00:   return LAT_SCALAR;
            2'b01:   return LAT_MEM;
            2'b10:   return LAT_VEC;
            default: return LAT_VFP;
        endcase
    endfunction

    // An entry only blocks while its result is still more than one cycle from write-back.
    always_comb begin
        conflict = 1'b0;
        wr_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 3; s++) begin
                wr_match = id_src_vec_i[s] ? vector_wr_ens_i[i] : register_wr_ens_i[i];
                if (id_src_use_i[s] && wr_match &&
                    (write_registers_i[i] == id_src_reg_i[s]) &&
                    !(!id_src_vec_i[s] && (id_src_reg_i[s] == 5'd0)) &&
                    (i < lat_of(op_types_i[i]) - 1))
                    conflict = 1'b1;
            end
        end
    end

    assign hazard     = id_valid_i & conflict;
    assign fifo_clear = ~(|vector_wr_ens_i) & ~(|register_wr_ens_i);

    assign stall_o   = (state_q == ST_DRAIN) | ((state_q == ST_RUN) & drain_req_i) | hazard;
    assign issue_o   = id_valid_i & ~stall_o & ~freeze_i;
    assign fifo_en_o = ~freeze_i;

    assign fifo_op_type_o   = issue_o ? id_op_type_i   : 2'b00;
    assign fifo_wr_reg_o    = issue_o ? id_dst_reg_i   : 5'd0;
    assign fifo_vec_wr_en_o = issue_o & id_vec_wr_en_i;
    assign fifo_reg_wr_en_o = issue_o & id_reg_wr_en_i;

    assign drain_done_o     = (state_q == ST_DRAIN) & fifo_clear & ~freeze_i;
    assign hazard_timeout_o = hazard_timeout_q;

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        if (!freeze_i) begin
            case (state_q)
                ST_RUN: begin
                    if (drain_req_i)  state_d = ST_DRAIN;
                    else if (hazard)  state_d = ST_STALL;
                end
                ST_STALL: begin
                    if (!hazard)      state_d = ST_RUN;
                end
                ST_DRAIN: begin
                    if (fifo_clear)   state_d = ST_RUN;
                end
                default:              state_d = ST_RUN;
            endcase
            if (issue_o)
                stall_cnt_d = 16'd0;
            else if (stall_o && (stall_cnt_q != 16'hFFFF))
                stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RUN;
            stall_cnt_q      <= 16'd0;
            hazard_timeout_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            stall_cnt_q      <= stall_cnt_d;
            hazard_timeout_q <= hazard_timeout_q | (stall_cnt_q == TIMEOUT_CNT);
        end
    end

`ifdef HAZARD_ISSUE_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_issue_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_issue_q <= 32'd0;
        end else if (!freeze_i) begin
            if (stall_o) perf_stall_q <= perf_stall_q + 32'd1;
            if (issue_o) perf_issue_q <= perf_issue_q + 32'd1;
        end
    end

    assign perf_stall_cycles_o = perf_stall_q;
    assign perf_issue_cnt_o    = perf_issue_q;
`else
    // Counters are left out of this build entirely.
`endif

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Bench for hazard_issue_ctrl: directed hazard/drain/freeze/watchdog cases, then random traffic vs a reference model.
`timescale 1ns/1ps
module tb_hazard_issue_ctrl;

    localparam int DEPTH = 9;
    localparam int TMO   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                  freeze, id_valid, drain_req;
    logic [2:0][4:0]       src_reg;
    logic [2:0]            src_vec, src_use;
    logic [1:0]            op_type;
    logic [4:0]            dst_reg;
    logic                  vwe, rwe;
    logic [DEPTH-1:0][1:0] f_op;
    logic [DEPTH-1:0]      f_vw, f_rw;
    logic [DEPTH-1:0][4:0] f_dst;

    logic       stall, issue, fifo_en, p_vw, p_rw, ddone, tmo;
    logic [1:0] p_op;
    logic [4:0] p_dst;

    hazard_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .freeze_i(freeze), .id_valid_i(id_valid),
        .id_src_reg_i(src_reg), .id_src_vec_i(src_vec), .id_src_use_i(src_use),
        .id_op_type_i(op_type), .id_dst_reg_i(dst_reg), .id_vec_wr_en_i(vwe),
        .id_reg_wr_en_i(rwe), .drain_req_i(drain_req), .op_types_i(f_op),
        .vector_wr_ens_i(f_vw), .register_wr_ens_i(f_rw), .write_registers_i(f_dst),
        .stall_o(stall), .issue_o(issue), .fifo_en_o(fifo_en), .fifo_op_type_o(p_op),
        .fifo_wr_reg_o(p_dst), .fifo_vec_wr_en_o(p_vw), .fifo_reg_wr_en_o(p_rw),
        .drain_done_o(ddone), .hazard_timeout_o(tmo));

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: mode flags, stall counter, sticky timeout
    bit m_drain, m_stalled, m_to;
    int m_cnt;
    bit obs_issue, obs_stall, obs_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic [1:0] op);
        int t[4] = '{3, 5, 4, 9};
        return t[op];
    endfunction

    task automatic clear_model();
        m_drain = 0; m_stalled = 0; m_to = 0; m_cnt = 0;
        f_op = '0; f_vw = '0; f_rw = '0; f_dst = '0;
    endtask

    task automatic idle();
        id_valid = 0; src_reg = '0; src_vec = '0; src_use = '0;
        op_type = 2'b00; dst_reg = 5'd0; vwe = 0; rwe = 0; drain_req = 0; freeze = 0;
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [4:0] dst, input logic v, input logic r);
        id_valid = 1; op_type = op; dst_reg = dst; vwe = v; rwe = r; src_use = '0;
    endtask

    task automatic set_src0(input logic [4:0] r, input logic isvec);
        src_reg[0] = r; src_vec[0] = isvec; src_use = 3'b001;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_model();
        #1;
        chk("rst_timeout", {31'd0, tmo}, 32'd0);
        chk("rst_drain_done", {31'd0, ddone}, 32'd0);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic cycle();
        bit hz, clr, e_stall, e_issue, e_done;
        @(negedge clk); #1;
        hz = 0;
        for (int i = 0; i < DEPTH; i++)
            for (int s = 0; s < 3; s++)
                if (src_use[s] && (src_vec[s] ? f_vw[i] : f_rw[i]) && f_dst[i] == src_reg[s]
                    && (src_vec[s] || src_reg[s] != 0) && i <= lat(f_op[i]) - 2)
                    hz = 1;
        hz      = hz && id_valid;
        clr     = (f_vw == '0) && (f_rw == '0);
        e_stall = m_drain || (!m_drain && !m_stalled && drain_req) || hz;
        e_issue = id_valid && !e_stall && !freeze;
        e_done  = m_drain && clr && !freeze;
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        chk("issue", {31'd0, issue}, {31'd0, e_issue});
        chk("fifo_en", {31'd0, fifo_en}, {31'd0, !freeze});
        chk("push_op", {30'd0, p_op}, e_issue ? {30'd0, op_type} : 32'd0);
        chk("push_dst", {27'd0, p_dst}, e_issue ? {27'd0, dst_reg} : 32'd0);
        chk("push_vwe", {31'd0, p_vw}, {31'd0, e_issue && vwe});
        chk("push_rwe", {31'd0, p_rw}, {31'd0, e_issue && rwe});
        chk("drain_done", {31'd0, ddone}, {31'd0, e_done});
        chk("hazard_timeout", {31'd0, tmo}, {31'd0, m_to});
        obs_issue = issue; obs_stall = stall; obs_done = ddone;
        @(posedge clk); #1;
        if (m_cnt == TMO) m_to = 1;
        if (!freeze) begin
            if (m_drain)            m_drain = !clr;
            else if (!m_stalled)    begin if (drain_req) m_drain = 1; else if (hz) m_stalled = 1; end
            else if (!hz)           m_stalled = 0;
            if (e_issue)            m_cnt = 0;
            else if (e_stall)       m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            for (int i = DEPTH - 1; i > 0; i--) begin
                f_op[i] = f_op[i-1]; f_vw[i] = f_vw[i-1]; f_rw[i] = f_rw[i-1]; f_dst[i] = f_dst[i-1];
            end
            f_op[0]  = e_issue ? op_type : 2'b00;
            f_dst[0] = e_issue ? dst_reg : 5'd0;
            f_vw[0]  = e_issue && vwe;
            f_rw[0]  = e_issue && rwe;
        end
    endtask

    task automatic run_until_issue(input string tag, input int exp_stalls);
        int  n = 0;
        bit  got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            if (obs_issue) got = 1;
            else n += obs_stall;
        end
        chk({tag, "_issued"}, {31'd0, got}, 32'd1);
        chk({tag, "_stall_cycles"}, n, exp_stalls);
    endtask

    initial begin
        idle();
        clear_model();
        do_reset();

        // scalar ALU result, LAT 3: blocks while at entries 0..1
        set_instr(2'b00, 5'd3, 0, 1); cycle();
        chk("add_issue", {31'd0, obs_issue}, 32'd1);
        set_instr(2'b00, 5'd4, 0, 0); set_src0(5'd3, 0);
        run_until_issue("add_r3", 2);

        do_reset(); idle();
        set_instr(2'b01, 5'd5, 0, 1); cycle();
        set_instr(2'b00, 5'd6, 0, 0); set_src0(5'd5, 0);
        run_until_issue("load_r5", 4);

        // vector write must not block a scalar read of the same index
        do_reset(); idle();
        set_instr(2'b11, 5'd2, 1, 0); cycle();
        set_instr(2'b00, 5'd7, 0, 0); set_src0(5'd2, 0);
        run_until_issue("vfp_scalar_r2", 0);

        do_reset(); idle();
        set_instr(2'b00, 5'd0, 0, 1); cycle();
        set_instr(2'b00, 5'd8, 0, 1); set_src0(5'd0, 0);
        run_until_issue("read_r0", 0);
        idle(); cycle();

        // fence with a vector write sitting at entry 4
        do_reset(); idle();
        set_instr(2'b10, 5'd1, 1, 0); cycle();
        idle();
        repeat (4) cycle();
        drain_req = 1; cycle();
        chk("drain_req_stall", {31'd0, obs_stall}, 32'd1);
        drain_req = 0;
        begin
            int k = 0;
            bit done = 0;
            while (!done && k < 15) begin k++; cycle(); done = obs_done; end
            chk("drain_cycles", k, 5);
        end
        cycle();
        chk("drain_done_pulse", {31'd0, obs_done}, 32'd0);

        // freeze in the middle of a load-use stall
        do_reset(); idle();
        set_instr(2'b01, 5'd5, 0, 1); cycle();
        set_instr(2'b00, 5'd6, 0, 0); set_src0(5'd5, 0);
        cycle();
        chk("pre_freeze_stall", {31'd0, obs_stall}, 32'd1);
        freeze = 1;
        repeat (3) cycle();
        freeze = 0;
        run_until_issue("after_freeze", 3);

        // vfp load-use stall lasts 8 cycles, reaching the watchdog limit
        do_reset(); idle();
        set_instr(2'b11, 5'd2, 1, 0); cycle();
        set_instr(2'b00, 5'd9, 0, 0); set_src0(5'd2, 1);
        run_until_issue("vfp_v2", 8);
        idle();
        repeat (3) cycle();
        chk("timeout_sticky", {31'd0, tmo}, 32'd1);
        do_reset(); idle();
        cycle();
        chk("timeout_cleared", {31'd0, tmo}, 32'd0);

        // random traffic over a small register range to provoke hazards
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            id_valid  = ($urandom_range(0, 9) < 8);
            freeze    = ($urandom_range(0, 9) == 0);
            drain_req = ($urandom_range(0, 29) == 0);
            for (int s = 0; s < 3; s++) begin
                src_reg[s] = 5'($urandom_range(0, 3));
                src_vec[s] = 1'($urandom_range(0, 1));
                src_use[s] = 1'($urandom_range(0, 1));
            end
            op_type = 2'($urandom_range(0, 3));
            dst_reg = 5'($urandom_range(0, 3));
            vwe     = 1'($urandom_range(0, 1));
            rwe     = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
